// File: rtl/meteor_pkg.sv
// Shared constants and types for the meteor pipeline: screen geometry,
// coordinate width, spawner LFSR taps and spawner FSM encoding.
package meteor_pkg;

    localparam int COORD_W = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        LOAD = 2'd2
    } spawn_state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR; free-runs every cycle outside reset.
module lfsr16
    import meteor_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else begin
            state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/meteor_spawner.sv
// Meteor slot pool: paces spawns by frame gap, picks a random Y/size from an
// LFSR and pulses a one-hot load into the lowest free slot.
module meteor_spawner #(
    parameter int          NUM_SLOTS = 4,
    parameter int          SCREEN_W  = meteor_pkg::SCREEN_W,
    parameter int          SCREEN_H  = meteor_pkg::SCREEN_H,
    parameter int          MIN_SIZE  = 16,
    parameter int          SPAWN_GAP = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_tick,
    input  logic                 game_run,
    input  logic [NUM_SLOTS-1:0] passed_left,
    output logic [NUM_SLOTS-1:0] slot_active,
    output logic [NUM_SLOTS-1:0] spawn_load,
    output logic [9:0]           spawn_x,
    output logic [9:0]           spawn_y,
    output logic [9:0]           spawn_size,
    output logic [7:0]           spawn_count
);
    import meteor_pkg::*;

    localparam logic [7:0] GAP_INIT = 8'(SPAWN_GAP);

    logic [15:0]          lfsr;
    logic [1:0]           unused_lfsr_bits;
    spawn_state_t         state;
    logic [7:0]           gap;
    logic [NUM_SLOTS-1:0] free_onehot;
    logic                 free_found;
    logic [COORD_W-1:0]   pick_size;
    logic [COORD_W-1:0]   pick_room;
    logic [COORD_W-1:0]   pick_yraw;
    logic [COORD_W-1:0]   pick_y;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    assign spawn_x          = COORD_W'(SCREEN_W);
    assign unused_lfsr_bits = lfsr[6:5];

    always_comb begin
        free_onehot = '0;
        free_found  = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_active[i] && !free_found) begin
                free_onehot[i] = 1'b1;
                free_found     = 1'b1;
            end
        end
    end

    // Clamp keeps the whole meteor on screen: top Y never exceeds SCREEN_H - size.
    assign pick_size = COORD_W'(MIN_SIZE) + COORD_W'(lfsr[4:0]);
    assign pick_room = COORD_W'(SCREEN_H) - pick_size;
    assign pick_yraw = {1'b0, lfsr[15:7]};
    assign pick_y    = (pick_yraw <= pick_room) ? pick_yraw : pick_room;

    // spawn_load is a one-cycle strobe with no back-pressure; spawn_y and
    // spawn_size are valid exactly while it is high and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gap         <= GAP_INIT;
            slot_active <= '0;
            spawn_load  <= '0;
            spawn_y     <= '0;
            spawn_size  <= '0;
            spawn_count <= '0;
        end else if (!game_run) begin
            state       <= IDLE;
            gap         <= GAP_INIT;
            slot_active <= '0;
            spawn_load  <= '0;
        end else begin
            spawn_load  <= '0;
            // spawn_load is nonzero only in LOAD, so the OR lets a load win over a release.
            slot_active <= (slot_active & ~passed_left) | spawn_load;
            if (frame_tick && gap != 8'd0) begin
                gap <= gap - 8'd1;
            end
            case (state)
                IDLE: begin
                    if (gap == 8'd0 && !(&slot_active)) begin
                        state <= PICK;
                    end
                end
                PICK: begin
                    if (free_found) begin
                        spawn_load <= free_onehot;
                        spawn_y    <= pick_y;
                        spawn_size <= pick_size;
                        state      <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    gap   <= GAP_INIT;
                    state <= IDLE;
                    if (spawn_count != 8'hFF) begin
                        spawn_count <= spawn_count + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_meteor_spawner.sv
// Bench for meteor_spawner: directed scenarios plus random traffic, checked
// each cycle against a behavioural slot-pool model and a load scoreboard.
module tb_meteor_spawner;

    localparam int          NS   = 4;
    localparam int          GAP  = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_prev(input logic [15:0] s);
        if (s[15]) return 16'(((s ^ 16'hB400) << 1) | 16'h0001);
        return 16'(s << 1);
    endfunction

    localparam logic [15:0] SEED_A = lfsr_prev(lfsr_prev(16'hFFFF));
    localparam logic [15:0] SEED_B = lfsr_prev(lfsr_prev(16'h0500));

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, frame_tick, game_run;
    logic [NS-1:0] passed_left;
    logic [NS-1:0] slot_active, spawn_load;
    logic [9:0]    spawn_x, spawn_y, spawn_size;
    logic [7:0]    spawn_count;

    logic          rst2, run2, tick2;
    logic [NS-1:0] a_active, a_load, b_active, b_load;
    logic [9:0]    a_x, a_y, a_size, b_x, b_y, b_size;
    logic [7:0]    a_count, b_count;

    meteor_spawner #(.NUM_SLOTS(NS), .SPAWN_GAP(GAP), .LFSR_SEED(SEED)) u_dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_run(game_run),
        .passed_left(passed_left), .slot_active(slot_active), .spawn_load(spawn_load),
        .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_size(spawn_size), .spawn_count(spawn_count)
    );

    meteor_spawner #(.NUM_SLOTS(NS), .SPAWN_GAP(1), .LFSR_SEED(SEED_A)) u_dut_a (
        .clk(clk), .rst(rst2), .frame_tick(tick2), .game_run(run2),
        .passed_left(4'b0000), .slot_active(a_active), .spawn_load(a_load),
        .spawn_x(a_x), .spawn_y(a_y), .spawn_size(a_size), .spawn_count(a_count)
    );

    meteor_spawner #(.NUM_SLOTS(NS), .SPAWN_GAP(1), .LFSR_SEED(SEED_B)) u_dut_b (
        .clk(clk), .rst(rst2), .frame_tick(tick2), .game_run(run2),
        .passed_left(4'b0000), .slot_active(b_active), .spawn_load(b_load),
        .spawn_x(b_x), .spawn_y(b_y), .spawn_size(b_size), .spawn_count(b_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: slots as a bit array, counters as plain ints.
    logic [15:0] m_lfsr;
    int          m_gap, m_count, m_y, m_size, m_load;
    bit          m_picking;
    bit          m_act[NS];
    logic [23:0] exp_q[$];

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [NS-1:0] act_mask();
        logic [NS-1:0] m;
        for (int i = 0; i < NS; i++) m[i] = m_act[i];
        return m;
    endfunction

    function automatic logic [NS-1:0] load_mask();
        return (m_load >= 0) ? NS'(1 << m_load) : '0;
    endfunction

    task automatic model_edge();
        logic [15:0] r;
        bit          old_act[NS];
        int          g0, was_load, f, yraw, room;
        bit          was_pick, any_free;
        if (rst) begin
            m_lfsr = SEED; m_gap = GAP; m_count = 0; m_y = 0; m_size = 0;
            m_load = -1; m_picking = 0;
            for (int i = 0; i < NS; i++) m_act[i] = 0;
            return;
        end
        r = m_lfsr;
        m_lfsr = lfsr_next(r);
        if (!game_run) begin
            for (int i = 0; i < NS; i++) m_act[i] = 0;
            m_gap = GAP; m_load = -1; m_picking = 0;
            return;
        end
        old_act = m_act; g0 = m_gap; was_load = m_load; was_pick = m_picking;
        for (int i = 0; i < NS; i++) if (passed_left[i]) m_act[i] = 0;
        if (was_load >= 0) begin
            m_act[was_load] = 1;
            m_gap = GAP;
            m_count = (m_count < 255) ? m_count + 1 : 255;
        end else if (frame_tick && m_gap > 0) begin
            m_gap--;
        end
        m_load = -1; m_picking = 0;
        any_free = 0; f = -1;
        for (int i = NS - 1; i >= 0; i--) if (!old_act[i]) begin any_free = 1; f = i; end
        if (was_pick) begin
            if (f >= 0) begin
                m_load = f;
                m_size = 16 + (r % 32);
                yraw   = r / 128;
                room   = 480 - m_size;
                m_y    = (yraw <= room) ? yraw : room;
                exp_q.push_back({4'(1 << f), 10'(m_y), 10'(m_size)});
            end
        end else if (was_load < 0 && g0 == 0 && any_free) begin
            m_picking = 1;
        end
    endtask

    task automatic compare_all();
        logic [23:0] e;
        check("spawn_load", spawn_load, load_mask());
        check("slot_active", slot_active, act_mask());
        check("spawn_count", spawn_count, m_count);
        check("spawn_x", spawn_x, 640);
        check("spawn_y", spawn_y, m_y);
        check("spawn_size", spawn_size, m_size);
        if (spawn_load != '0) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_load", spawn_load, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_load", {spawn_load, spawn_y, spawn_size}, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int loads_seen, load_idx[$];
        logic [NS-1:0] load_msk[$];
        bit found;
        int cnt_before;

        rst = 1; game_run = 0; frame_tick = 0; passed_left = '0;
        rst2 = 1; run2 = 0; tick2 = 0;
        repeat (3) step();
        check("reset_active", slot_active, 0);
        check("reset_count", spawn_count, 0);
        check("reset_y", spawn_y, 0);
        rst = 0;

        // game_run low: ticks must not spawn
        loads_seen = 0;
        for (int i = 0; i < 100; i++) begin
            frame_tick = (i % 20 == 19);
            step();
            if (spawn_load != '0) loads_seen++;
        end
        frame_tick = 0;
        check("idle_no_load", loads_seen, 0);
        check("idle_count", spawn_count, 0);
        check("idle_spawn_x", spawn_x, 640);

        // Fill all four slots, one spawn per two ticks
        game_run = 1;
        for (int i = 0; i < 200; i++) begin
            frame_tick = (i % 20 == 0);
            step();
            if (spawn_load != '0) begin
                load_idx.push_back(i);
                load_msk.push_back(spawn_load);
            end
        end
        frame_tick = 0;
        check("fill_loads", load_idx.size(), 4);
        if (load_idx.size() == 4) begin
            check("fill_first_cycle", load_idx[0], 22);
            check("fill_second_cycle", load_idx[1], 62);
            check("fill_mask0", load_msk[0], 4'b0001);
            check("fill_mask1", load_msk[1], 4'b0010);
            check("fill_mask2", load_msk[2], 4'b0100);
            check("fill_mask3", load_msk[3], 4'b1000);
        end
        check("fill_count", spawn_count, 4);
        check("fill_active", slot_active, 4'b1111);

        // Full pool defers spawns; release of slot 2 lets one through
        loads_seen = 0;
        for (int i = 0; i < 60; i++) begin
            frame_tick = (i % 20 == 0);
            step();
            if (spawn_load != '0) loads_seen++;
        end
        frame_tick = 0;
        check("full_no_load", loads_seen, 0);
        passed_left = 4'b0100;
        step();
        passed_left = '0;
        check("release_slot2", slot_active, 4'b1011);
        step();
        step();
        check("deferred_load_slot2", spawn_load, 4'b0100);
        step();
        check("deferred_active", slot_active, 4'b1111);

        // Release coinciding with the load of slot 1
        game_run = 0;
        step();
        game_run = 1;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            frame_tick = (i % 20 == 0);
            step();
            frame_tick = 0;
            if (spawn_load == 4'b0010) begin
                found = 1;
                passed_left = 4'b0011;
                step();
                passed_left = '0;
                check("load_beats_release", slot_active, 4'b0010);
            end
        end
        check("load_slot1_seen", found, 1);

        // Reset during PICK aborts the spawn
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            frame_tick = (i % 20 == 0);
            step();
            frame_tick = 0;
            if (m_picking) begin
                found = 1;
                rst = 1;
                step();
                rst = 0;
                check("pick_rst_load", spawn_load, 0);
                check("pick_rst_active", slot_active, 0);
                check("pick_rst_count", spawn_count, 0);
                check("pick_rst_size", spawn_size, 0);
            end
        end
        check("pick_seen", found, 1);

        // game_run drop with three live slots
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            frame_tick = (i % 20 == 0);
            step();
            frame_tick = 0;
            if (m_count == 3 && m_load < 0) found = 1;
        end
        check("three_loaded", found, 1);
        check("three_active", slot_active, 4'b0111);
        cnt_before = spawn_count;
        game_run = 0;
        step();
        check("drop_active", slot_active, 0);
        check("drop_count", spawn_count, cnt_before);

        // Random traffic
        game_run = 1;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 199) == 0) game_run = ~game_run;
            frame_tick = ($urandom_range(0, 5) == 0);
            passed_left = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            step();
        end
        rst = 0; game_run = 0; frame_tick = 0; passed_left = '0;

        // Placement extremes via seeds rewound two steps from the PICK value
        step();
        step();
        rst2 = 0; run2 = 1; tick2 = 1;
        step();
        tick2 = 0;
        step();
        check("edge_no_early_load", a_load, 0);
        step();
        check("edge_a_load", a_load, 4'b0001);
        check("edge_a_size", a_size, 47);
        check("edge_a_y", a_y, 433);
        check("edge_a_x", a_x, 640);
        check("edge_b_load", b_load, 4'b0001);
        check("edge_b_size", b_size, 16);
        check("edge_b_y", b_y, 10);
        step();
        check("edge_a_active", a_active, 4'b0001);
        check("edge_b_count", b_count, 1);
        check("edge_b_x", b_x, 640);

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
